// File: rtl/unidad_carga_almacen_pkg.sv
// Shared definitions for the load/store unit: FSM states, access-size
// encodings and the alignment rule used when EXCEP_ALINEACION_EN is defined.
package paquete_carga_almacen;

  typedef enum logic [1:0] {
    REPOSO   = 2'b00,
    LEER     = 2'b01,
    ESCRIBIR = 2'b10,
    FIN      = 2'b11
  } estado_t;

  localparam logic [1:0] TAM_BYTE    = 2'b00;
  localparam logic [1:0] TAM_MEDIA   = 2'b01;
  localparam logic [1:0] TAM_PALABRA = 2'b10;

  // Both 10 and 11 encode a full word access.
  function automatic logic es_palabra(input logic [1:0] tam);
    return tam[1];
  endfunction

  // Halfwords must sit on even addresses and words on multiples of four.
  function automatic logic es_desalineado(input logic [1:0] tam, input logic [1:0] desp);
    return ((tam == TAM_MEDIA) && desp[0]) || (es_palabra(tam) && (desp != 2'b00));
  endfunction

endpackage

// File: rtl/unidad_carga_almacen_alineador.sv
// Byte-lane aligner: merges store data into a memory word and extracts a
// load lane with sign or zero extension. Little-endian lanes; halfword lane
// chosen by desp[1] only, so desp[0] is ignored for halfwords and desp is
// ignored entirely for words.
module alineador_bytes
  import paquete_carga_almacen::*;
(
  input  logic [1:0]  tam,
  input  logic [1:0]  desp,
  input  logic        sig,
  input  logic [31:0] palabra,
  input  logic [31:0] dato,
  output logic [31:0] fusion,
  output logic [31:0] extraido
);

  logic [7:0]  byte_sel;
  logic [15:0] media_sel;

  // Lane merge for stores and lane extract plus extension for loads.
  always_comb begin
    byte_sel  = palabra[{desp, 3'b000} +: 8];
    media_sel = desp[1] ? palabra[31:16] : palabra[15:0];
    fusion    = palabra;
    extraido  = palabra;
    if (es_palabra(tam)) begin
      fusion   = dato;
      extraido = palabra;
    end else if (tam == TAM_MEDIA) begin
      if (desp[1]) begin
        fusion[31:16] = dato[15:0];
      end else begin
        fusion[15:0] = dato[15:0];
      end
      extraido = {{16{sig & media_sel[15]}}, media_sel};
    end else begin
      fusion[{desp, 3'b000} +: 8] = dato[7:0];
      extraido = {{24{sig & byte_sel[7]}}, byte_sel};
    end
  end

endmodule

// File: rtl/unidad_carga_almacen.sv
// Load/store unit between a processor request port and a word-wide data
// memory. Sub-word stores are done as read-modify-write. Optional feature:
// define EXCEP_ALINEACION_EN to reject misaligned requests with error_alin
// instead of silently aligning them down.
module unidad_carga_almacen
  import paquete_carga_almacen::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        sol_valida,
  output logic        sol_lista,
  input  logic        sol_escr,
  input  logic [1:0]  sol_tam,
  input  logic        sol_sig,
  input  logic [9:0]  sol_dir,
  input  logic [31:0] sol_dato,
  output logic        resp_valida,
  output logic [31:0] resp_dato,
  output logic        error_alin,
  output logic        EscrMem,
  output logic        LeerMem,
  output logic [7:0]  Direc,
  output logic [31:0] Datain,
  input  logic [31:0] Dataout
);

  estado_t     estado;
  logic        escr_r;
  logic [1:0]  tam_r;
  logic        sig_r;
  logic [9:0]  dir_r;
  logic [31:0] dato_r;
  logic        desalineado;
  logic [31:0] fusion;
  logic [31:0] extraido;

`ifdef EXCEP_ALINEACION_EN
  logic error_r;
  assign desalineado = es_desalineado(sol_tam, sol_dir[1:0]);
  assign error_alin  = error_r;
`else
  assign desalineado = 1'b0;
  assign error_alin  = 1'b0;
`endif

  assign sol_lista = (estado == REPOSO);

  // The aligner works straight on Dataout during LEER so that the merged
  // word and the extracted lane are captured on the edge that leaves LEER.
  alineador_bytes u_alineador (
    .tam      (tam_r),
    .desp     (dir_r[1:0]),
    .sig      (sig_r),
    .palabra  (Dataout),
    .dato     (dato_r),
    .fusion   (fusion),
    .extraido (extraido)
  );

  // Request FSM with registered memory-side and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado      <= REPOSO;
      escr_r      <= 1'b0;
      tam_r       <= 2'b00;
      sig_r       <= 1'b0;
      dir_r       <= '0;
      dato_r      <= '0;
      EscrMem     <= 1'b0;
      LeerMem     <= 1'b0;
      Direc       <= '0;
      Datain      <= '0;
      resp_valida <= 1'b0;
      resp_dato   <= '0;
`ifdef EXCEP_ALINEACION_EN
      error_r     <= 1'b0;
`endif
    end else begin
      case (estado)
        REPOSO: begin
          EscrMem     <= 1'b0;
          LeerMem     <= 1'b0;
          Direc       <= '0;
          Datain      <= '0;
          resp_valida <= 1'b0;
          if (sol_valida) begin
            escr_r <= sol_escr;
            tam_r  <= sol_tam;
            sig_r  <= sol_sig;
            dir_r  <= sol_dir;
            dato_r <= sol_dato;
            if (desalineado) begin
              estado      <= FIN;
              resp_valida <= 1'b1;
              resp_dato   <= '0;
`ifdef EXCEP_ALINEACION_EN
              error_r     <= 1'b1;
`endif
            end else if (sol_escr && es_palabra(sol_tam)) begin
              estado  <= ESCRIBIR;
              EscrMem <= 1'b1;
              Direc   <= sol_dir[9:2];
              Datain  <= sol_dato;
            end else begin
              estado  <= LEER;
              LeerMem <= 1'b1;
              Direc   <= sol_dir[9:2];
            end
          end
        end
        LEER: begin
          LeerMem <= 1'b0;
          if (escr_r) begin
            estado  <= ESCRIBIR;
            EscrMem <= 1'b1;
            Direc   <= dir_r[9:2];
            Datain  <= fusion;
          end else begin
            estado      <= FIN;
            Direc       <= '0;
            resp_valida <= 1'b1;
            resp_dato   <= extraido;
          end
        end
        ESCRIBIR: begin
          estado      <= FIN;
          EscrMem     <= 1'b0;
          Direc       <= '0;
          Datain      <= '0;
          resp_valida <= 1'b1;
          resp_dato   <= '0;
        end
        FIN: begin
          estado      <= REPOSO;
          resp_valida <= 1'b0;
`ifdef EXCEP_ALINEACION_EN
          error_r     <= 1'b0;
`endif
        end
        default: begin
          estado <= REPOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unidad_carga_almacen.sv
// Self-checking bench for unidad_carga_almacen: directed vectors, random
// traffic against a word-array reference model, ignored requests while
// busy, and reset during a read-modify-write.
module tb_unidad_carga_almacen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sol_valida = 1'b0;
  logic        sol_escr = 1'b0;
  logic [1:0]  sol_tam = 2'b00;
  logic        sol_sig = 1'b0;
  logic [9:0]  sol_dir = '0;
  logic [31:0] sol_dato = '0;
  logic        sol_lista;
  logic        resp_valida;
  logic [31:0] resp_dato;
  logic        error_alin;
  logic        EscrMem;
  logic        LeerMem;
  logic [7:0]  Direc;
  logic [31:0] Datain;
  logic [31:0] Dataout;

  logic [31:0] tb_mem [256];
  logic [31:0] ref_mem [256];

  int n_comp = 0;
  int n_fail = 0;

  typedef struct {
    int          lat;
    logic [31:0] dato;
    logic        err;
    int          n_leer;
    int          n_escr;
    logic [7:0]  direc;
    logic [31:0] palabra;
  } esperado_t;

  unidad_carga_almacen dut (
    .clk         (clk),
    .reset       (reset),
    .sol_valida  (sol_valida),
    .sol_lista   (sol_lista),
    .sol_escr    (sol_escr),
    .sol_tam     (sol_tam),
    .sol_sig     (sol_sig),
    .sol_dir     (sol_dir),
    .sol_dato    (sol_dato),
    .resp_valida (resp_valida),
    .resp_dato   (resp_dato),
    .error_alin  (error_alin),
    .EscrMem     (EscrMem),
    .LeerMem     (LeerMem),
    .Direc       (Direc),
    .Datain      (Datain),
    .Dataout     (Dataout)
  );

  always #5 clk = ~clk;

  // Data memory seen by the DUT: combinational read, write on the rising edge.
  assign Dataout = tb_mem[Direc];
  always @(posedge clk) if (EscrMem) tb_mem[Direc] = Datain;

  // Reference behaviour computed from sizes, offsets and masks.
  function automatic esperado_t modelo(input logic escr, input logic [1:0] tam, input logic sig,
                                       input logic [9:0] dir, input logic [31:0] dato,
                                       input logic [31:0] palabra);
    esperado_t e;
    int bytes, off, shift;
    logic desal;
    logic [63:0] mask;
    logic [31:0] m32, v;
    bytes = (tam == 2'd0) ? 1 : (tam == 2'd1) ? 2 : 4;
    off = int'(dir % 10'd4);
    desal = 1'b0;
`ifdef EXCEP_ALINEACION_EN
    desal = (off % bytes) != 0;
`endif
    off = (off / bytes) * bytes;
    mask = (64'd1 << (8 * bytes)) - 64'd1;
    m32 = mask[31:0];
    shift = 8 * off;
    e.direc = 8'(dir / 10'd4);
    e.palabra = palabra;
    e.err = 1'b0;
    e.n_leer = 0;
    e.n_escr = 0;
    e.dato = '0;
    if (desal) begin
      e.lat = 1;
      e.err = 1'b1;
    end else if (escr) begin
      e.n_escr = 1;
      e.n_leer = (bytes == 4) ? 0 : 1;
      e.lat = (bytes == 4) ? 2 : 3;
      e.palabra = (palabra & ~(m32 << shift)) | ((dato & m32) << shift);
    end else begin
      e.n_leer = 1;
      e.lat = 2;
      v = (palabra >> shift) & m32;
      if (sig && bytes < 4 && v[8 * bytes - 1]) v = v | ~m32;
      e.dato = v;
    end
    return e;
  endfunction

  // Drives one request and records what the DUT does until resp_valida.
  task automatic transaccion(input logic escr, input logic [1:0] tam, input logic sig,
                             input logic [9:0] dir, input logic [31:0] dato, input bit ruido,
                             output int lat, output logic [31:0] r_dato, output logic r_err,
                             output int n_leer, output int n_escr, output logic [7:0] dir_leer,
                             output logic [7:0] dir_escr, output logic [31:0] dat_escr,
                             output bit ambos, output bit lista_despues, output bit acepta);
    int espera = 0;
    lat = 0; r_dato = '0; r_err = 1'b0; n_leer = 0; n_escr = 0;
    dir_leer = '0; dir_escr = '0; dat_escr = '0; ambos = 0; lista_despues = 0;
    while (!sol_lista && espera < 20) begin
      @(negedge clk);
      espera++;
    end
    acepta = sol_lista;
    sol_escr = escr; sol_tam = tam; sol_sig = sig; sol_dir = dir; sol_dato = dato;
    sol_valida = 1'b1;
    @(posedge clk);
    #1;
    sol_valida = 1'b0;
    sol_escr = 1'($urandom); sol_tam = 2'($urandom); sol_sig = 1'($urandom);
    sol_dir = 10'($urandom); sol_dato = $urandom;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (LeerMem && EscrMem) ambos = 1;
      if (LeerMem) begin n_leer++; dir_leer = Direc; end
      if (EscrMem) begin n_escr++; dir_escr = Direc; dat_escr = Datain; end
      if (resp_valida) begin
        lat = c; r_dato = resp_dato; r_err = error_alin;
        sol_valida = 1'b0;
        break;
      end else if (ruido) begin
        sol_valida = 1'b1; sol_escr = 1'b1; sol_tam = 2'b10;
        sol_dir = 10'($urandom); sol_dato = $urandom;
      end
    end
    sol_valida = 1'b0;
    @(negedge clk);
    lista_despues = sol_lista;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_comp++;
    if ({sol_lista, EscrMem, LeerMem, resp_valida, error_alin} !== 5'b10000) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: got %b expected 10000", {sol_lista, EscrMem, LeerMem, resp_valida, error_alin});
    end
    n_comp++;
    if ({Direc, Datain, resp_dato} !== 72'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_datos: got Direc=%h Datain=%h resp_dato=%h expected zeros", Direc, Datain, resp_dato);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_comp++;
    if ({sol_lista, EscrMem, LeerMem, resp_valida} !== 4'b1000) begin
      n_fail++;
      $display("[TB] FAIL reposo_tras_reset: got %b expected 1000", {sol_lista, EscrMem, LeerMem, resp_valida});
    end
  endtask

  task automatic test_vectores();
    int lat, nl, ne;
    logic [31:0] rd, de;
    logic re;
    logic [7:0] dl, dw;
    bit amb, lis, acc;
    tb_mem[1] = 32'h00000003; ref_mem[1] = 32'h00000003;
    tb_mem[2] = 32'h8000000C; ref_mem[2] = 32'h8000000C;

    transaccion(1'b1, 2'b10, 1'b0, 10'h000, 32'h00000060, 0, lat, rd, re, nl, ne, dl, dw, de, amb, lis, acc);
    ref_mem[0] = 32'h00000060;
    n_comp++;
    if ({lat, ne, nl} !== {32'd2, 32'd1, 32'd0}) begin
      n_fail++; $display("[TB] FAIL palabra_escr_ciclos: got lat=%0d escr=%0d leer=%0d expected 2/1/0", lat, ne, nl);
    end
    n_comp++;
    if ({dw, de} !== {8'h00, 32'h00000060}) begin
      n_fail++; $display("[TB] FAIL palabra_escr_datos: got Direc=%h Datain=%h expected 00/00000060", dw, de);
    end

    transaccion(1'b1, 2'b00, 1'b0, 10'h006, 32'h000000AB, 0, lat, rd, re, nl, ne, dl, dw, de, amb, lis, acc);
    ref_mem[1] = 32'h00AB0003;
    n_comp++;
    if ({lat, nl, ne} !== {32'd3, 32'd1, 32'd1}) begin
      n_fail++; $display("[TB] FAIL byte_escr_ciclos: got lat=%0d leer=%0d escr=%0d expected 3/1/1", lat, nl, ne);
    end
    n_comp++;
    if ({dl, dw, de} !== {8'h01, 8'h01, 32'h00AB0003}) begin
      n_fail++; $display("[TB] FAIL byte_escr_datos: got rd=%h wr=%h Datain=%h expected 01/01/00AB0003", dl, dw, de);
    end

    transaccion(1'b0, 2'b00, 1'b1, 10'h006, 32'h0, 0, lat, rd, re, nl, ne, dl, dw, de, amb, lis, acc);
    n_comp++;
    if (rd !== 32'hFFFFFFAB || lat != 2) begin
      n_fail++; $display("[TB] FAIL byte_con_signo: got %h lat=%0d expected FFFFFFAB lat=2", rd, lat);
    end
    transaccion(1'b0, 2'b00, 1'b0, 10'h006, 32'h0, 0, lat, rd, re, nl, ne, dl, dw, de, amb, lis, acc);
    n_comp++;
    if (rd !== 32'h000000AB) begin
      n_fail++; $display("[TB] FAIL byte_sin_signo: got %h expected 000000AB", rd);
    end
    transaccion(1'b0, 2'b01, 1'b1, 10'h00A, 32'h0, 0, lat, rd, re, nl, ne, dl, dw, de, amb, lis, acc);
    n_comp++;
    if (rd !== 32'hFFFF8000) begin
      n_fail++; $display("[TB] FAIL media_con_signo: got %h expected FFFF8000", rd);
    end
    transaccion(1'b0, 2'b01, 1'b0, 10'h00A, 32'h0, 0, lat, rd, re, nl, ne, dl, dw, de, amb, lis, acc);
    n_comp++;
    if (rd !== 32'h00008000) begin
      n_fail++; $display("[TB] FAIL media_sin_signo: got %h expected 00008000", rd);
    end

    transaccion(1'b0, 2'b10, 1'b0, 10'h003, 32'h0, 0, lat, rd, re, nl, ne, dl, dw, de, amb, lis, acc);
`ifdef EXCEP_ALINEACION_EN
    n_comp++;
    if ({re, nl, rd} !== {1'b1, 32'd0, 32'd0}) begin
      n_fail++; $display("[TB] FAIL palabra_desalineada: got err=%b leer=%0d dato=%h expected 1/0/0", re, nl, rd);
    end
`else
    n_comp++;
    if ({re, dl, rd, lat} !== {1'b0, 8'h00, 32'h00000060, 32'd2}) begin
      n_fail++; $display("[TB] FAIL palabra_alineada_abajo: got err=%b Direc=%h dato=%h lat=%0d expected 0/00/00000060/2", re, dl, rd, lat);
    end
`endif
  endtask

  task automatic test_aleatorio(input int n, input bit ruido);
    int lat, nl, ne;
    logic [31:0] rd, de, dato;
    logic re, escr, sig;
    logic [1:0] tam;
    logic [9:0] dir;
    logic [7:0] dl, dw, idx;
    bit amb, lis, acc;
    esperado_t e;
    for (int i = 0; i < n; i++) begin
      escr = 1'($urandom); tam = 2'($urandom); sig = 1'($urandom);
      dir = 10'($urandom); dato = $urandom;
      idx = dir[9:2];
      e = modelo(escr, tam, sig, dir, dato, ref_mem[idx]);
      transaccion(escr, tam, sig, dir, dato, ruido, lat, rd, re, nl, ne, dl, dw, de, amb, lis, acc);
      n_comp++;
      if (!acc) begin n_fail++; $display("[TB] FAIL aceptacion[%0d]: got sol_lista=0 expected 1", i); end
      n_comp++;
      if (lat != e.lat) begin n_fail++; $display("[TB] FAIL latencia[%0d]: got %0d expected %0d", i, lat, e.lat); end
      n_comp++;
      if (rd !== e.dato) begin n_fail++; $display("[TB] FAIL resp_dato[%0d]: got %h expected %h", i, rd, e.dato); end
      n_comp++;
      if (re !== e.err) begin n_fail++; $display("[TB] FAIL error_alin[%0d]: got %b expected %b", i, re, e.err); end
      n_comp++;
      if (nl != e.n_leer || ne != e.n_escr) begin
        n_fail++; $display("[TB] FAIL accesos[%0d]: got leer=%0d escr=%0d expected %0d/%0d", i, nl, ne, e.n_leer, e.n_escr);
      end
      if (e.n_leer > 0) begin
        n_comp++;
        if (dl !== e.direc) begin n_fail++; $display("[TB] FAIL direc_leer[%0d]: got %h expected %h", i, dl, e.direc); end
      end
      if (e.n_escr > 0) begin
        n_comp++;
        if (dw !== e.direc || de !== e.palabra) begin
          n_fail++; $display("[TB] FAIL escritura[%0d]: got %h/%h expected %h/%h", i, dw, de, e.direc, e.palabra);
        end
      end
      n_comp++;
      if (amb) begin n_fail++; $display("[TB] FAIL leer_y_escr[%0d]: got both 1 expected exclusive", i); end
      n_comp++;
      if (!lis) begin n_fail++; $display("[TB] FAIL lista_tras_fin[%0d]: got 0 expected 1", i); end
      n_comp++;
      if (tb_mem[idx] !== e.palabra) begin
        n_fail++; $display("[TB] FAIL memoria[%0d]: got %h expected %h", i, tb_mem[idx], e.palabra);
      end
      ref_mem[idx] = e.palabra;
    end
  endtask

  task automatic test_reset_abortado();
    bit pulso = 0, escritura = 0;
    tb_mem[5] = 32'h12345678; ref_mem[5] = 32'h12345678;
    @(negedge clk);
    sol_escr = 1'b1; sol_tam = 2'b00; sol_sig = 1'b0; sol_dir = 10'h015; sol_dato = 32'h000000EE;
    sol_valida = 1'b1;
    @(posedge clk);
    #1;
    sol_valida = 1'b0;
    @(negedge clk);
    n_comp++;
    if (LeerMem !== 1'b1) begin n_fail++; $display("[TB] FAIL abortar_en_leer: got LeerMem=%b expected 1", LeerMem); end
    reset = 1'b1;
    #1;
    n_comp++;
    if ({EscrMem, LeerMem, sol_lista, resp_valida} !== 4'b0010) begin
      n_fail++; $display("[TB] FAIL reset_asincrono: got %b expected 0010", {EscrMem, LeerMem, sol_lista, resp_valida});
    end
    repeat (2) begin
      @(negedge clk);
      if (EscrMem) escritura = 1;
      if (resp_valida) pulso = 1;
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (EscrMem) escritura = 1;
      if (resp_valida) pulso = 1;
    end
    n_comp++;
    if (escritura || pulso) begin
      n_fail++; $display("[TB] FAIL abortar_sin_efecto: got escr=%0d pulso=%0d expected 0/0", escritura, pulso);
    end
    n_comp++;
    if (tb_mem[5] !== ref_mem[5]) begin
      n_fail++; $display("[TB] FAIL abortar_memoria: got %h expected %h", tb_mem[5], ref_mem[5]);
    end
    n_comp++;
    if (sol_lista !== 1'b1) begin n_fail++; $display("[TB] FAIL abortar_lista: got %b expected 1", sol_lista); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      tb_mem[i] = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    test_reset();
    test_vectores();
    test_aleatorio(80, 0);
    test_aleatorio(40, 1);
    test_reset_abortado();
    test_aleatorio(20, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_fail);
    $finish;
  end

endmodule
